fma_scheduler: RTL and testbench

FMA_SCHEDULER -- requirements
Module: fma_scheduler

---
 rtl/fma_scheduler.sv | 156 +++++++++++++++
 tb/tb_fma_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_scheduler.sv
// fma_scheduler
// Shares one posit fused multiply-add unit between two requesters.
// A request is granted in IDLE (round-robin on contention), its operands are
// parked on the fma_* outputs for LAT cycles, the FMA result is captured and
// held on rsp_* until the consumer takes it, then the block returns to IDLE.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   req_valid[1:0] / req_ready[1:0] per-requester request handshake
//   req_in1/2/3 [2*N-1:0]           operands, requester i at [i*N +: N]
//   req_op_N, req_op_sub [1:0]      per-requester negate / subtract controls
//   rsp_valid / rsp_ready           result handshake
//   rsp_id, rsp_data[N-1:0]         owner of the result and the result itself
//   fma_in1/2/3, fma_op_N/op_sub    operands and controls to the shared FMA
//   fma_out[N-1:0]                  combinational FMA result
//   busy                            high whenever the block is not IDLE
module fma_scheduler #(
    parameter int N   = 32,
    parameter int ES  = 2,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*N-1:0] req_in1,
    input  logic [2*N-1:0] req_in2,
    input  logic [2*N-1:0] req_in3,
    input  logic [1:0]     req_op_N,
    input  logic [1:0]     req_op_sub,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [N-1:0]   rsp_data,
    output logic [N-1:0]   fma_in1,
    output logic [N-1:0]   fma_in2,
    output logic [N-1:0]   fma_in3,
    output logic           fma_op_N,
    output logic           fma_op_sub,
    input  logic [N-1:0]   fma_out,
    output logic           busy
);

    // ES only matters to the FMA datapath; it is checked here together with
    // the latency range so an illegal configuration fails at elaboration.
    if (LAT < 1 || LAT > 15 || ES < 0) begin : g_bad_params
        $error("fma_scheduler: LAT must be 1..15 and ES non-negative");
    end

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt;
    logic       last_gnt;
    logic       gnt;
    logic       grant_en;
    logic       resp_load;
    logic       resp_clear;

    // Round-robin pick: on contention the requester that did not win last
    // time goes next; otherwise whichever single requester is asking.
    always_comb begin
        gnt = 1'b0;
        if (req_valid == 2'b11) begin
            gnt = ~last_gnt;
        end else begin
            gnt = req_valid[1];
        end
    end

    // Next-state and handshake decode. last_gnt doubles as the index of the
    // operation in flight because it only moves on a grant.
    always_comb begin
        state_d    = state_q;
        req_ready  = 2'b00;
        grant_en   = 1'b0;
        resp_load  = 1'b0;
        resp_clear = 1'b0;
        busy       = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_en       = 1'b1;
                    req_ready[gnt] = 1'b1;
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    resp_load = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    resp_clear = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: operand capture on a grant, latency countdown in
    // EXEC, result capture at the end of EXEC and release on rsp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 4'd0;
            last_gnt   <= 1'b1;
            fma_in1    <= '0;
            fma_in2    <= '0;
            fma_in3    <= '0;
            fma_op_N   <= 1'b0;
            fma_op_sub <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            if (grant_en) begin
                fma_in1    <= gnt ? req_in1[2*N-1:N] : req_in1[N-1:0];
                fma_in2    <= gnt ? req_in2[2*N-1:N] : req_in2[N-1:0];
                fma_in3    <= gnt ? req_in3[2*N-1:N] : req_in3[N-1:0];
                fma_op_N   <= req_op_N[gnt];
                fma_op_sub <= req_op_sub[gnt];
                last_gnt   <= gnt;
                cnt        <= CNT_LOAD;
            end else if (state_q == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (resp_load) begin
                rsp_data  <= fma_out;
                rsp_id    <= last_gnt;
                rsp_valid <= 1'b1;
            end else if (resp_clear) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fma_scheduler.sv
// tb_fma_scheduler
// Drives fma_scheduler with directed and randomized requests. A stand-in
// combinational FMA feeds fma_out; the reference model works at transaction
// level: it remembers when the current operation was accepted and derives
// every handshake from edge arithmetic (response visible from edge
// accept+LAT+1 until a cycle with rsp_ready, next accept one edge later).
module tb_fma_scheduler;

    localparam int N   = 32;
    localparam int ES  = 2;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     req_valid = '0;
    logic [1:0]     req_ready;
    logic [2*N-1:0] req_in1 = '0;
    logic [2*N-1:0] req_in2 = '0;
    logic [2*N-1:0] req_in3 = '0;
    logic [1:0]     req_op_N = '0;
    logic [1:0]     req_op_sub = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic           rsp_id;
    logic [N-1:0]   rsp_data;
    logic [N-1:0]   fma_in1;
    logic [N-1:0]   fma_in2;
    logic [N-1:0]   fma_in3;
    logic           fma_op_N;
    logic           fma_op_sub;
    logic [N-1:0]   fma_out;
    logic           busy;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state.
    bit         m_busy;
    int         m_acc;
    int         k;
    bit         m_id;
    bit         m_last;
    logic [N-1:0] m_data;
    logic [N-1:0] m_f1;
    logic [N-1:0] m_f2;
    logic [N-1:0] m_f3;
    bit         m_fn;
    bit         m_fs;

    // Stand-in FMA: exact for 1.0*1.0+1.0 = 2.0, otherwise a cheap mix that
    // makes every operand and control bit visible in the result.
    function automatic logic [N-1:0] fma_stub(input logic [N-1:0] a, b, c,
                                              input logic opn, ops);
        if (a == 32'h40000000 && b == 32'h40000000 && c == 32'h40000000 && !opn && !ops)
            return 32'h48000000;
        return ((a * b) + c) ^ {opn, ops, 30'h0} ^ {b[15:0], a[31:16]};
    endfunction

    function automatic bit pick(input logic [1:0] v, input bit last);
        if (v == 2'b11) return !last;
        return v[1];
    endfunction

    assign fma_out = fma_stub(fma_in1, fma_in2, fma_in3, fma_op_N, fma_op_sub);

    fma_scheduler #(.N(N), .ES(ES), .LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_in3    (req_in3),
        .req_op_N   (req_op_N),
        .req_op_sub (req_op_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .fma_in1    (fma_in1),
        .fma_in2    (fma_in2),
        .fma_in3    (fma_in3),
        .fma_op_N   (fma_op_N),
        .fma_op_sub (fma_op_sub),
        .fma_out    (fma_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_busy = 1'b0;
        m_acc  = 0;
        k      = 0;
        m_id   = 1'b0;
        m_last = 1'b1;
        m_data = '0;
        m_f1   = '0;
        m_f2   = '0;
        m_f3   = '0;
        m_fn   = 1'b0;
        m_fs   = 1'b0;
    endtask

    // Modes: 0 directed 1.0 operands on requester 0, 1 requester 1 only,
    // 2 both valid, 3 fully random, 4 both valid with consumer stalled,
    // 5 nobody requesting.
    task automatic applyStimulus(input int mode);
        req_in1    = {$urandom, $urandom};
        req_in2    = {$urandom, $urandom};
        req_in3    = {$urandom, $urandom};
        req_op_N   = 2'($urandom);
        req_op_sub = 2'($urandom);
        rsp_ready  = 1'b1;
        case (mode)
            0: begin
                req_valid  = 2'b01;
                req_in1    = {2{32'h40000000}};
                req_in2    = {2{32'h40000000}};
                req_in3    = {2{32'h40000000}};
                req_op_N   = 2'b00;
                req_op_sub = 2'b00;
            end
            1: req_valid = 2'b10;
            2: req_valid = 2'b11;
            3: begin
                req_valid = 2'($urandom);
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
            4: begin
                req_valid = 2'b11;
                rsp_ready = 1'b0;
            end
            default: req_valid = 2'b00;
        endcase
    endtask

    // Expected outputs during the cycle that ends at edge k+1.
    task automatic checkCycle();
        logic [1:0] exp_ready;
        bit         exp_rv;
        exp_ready = 2'b00;
        exp_rv    = 1'b0;
        if (!m_busy) begin
            if (|req_valid) exp_ready[pick(req_valid, m_last)] = 1'b1;
        end else begin
            exp_rv = ((k + 1) >= m_acc + LAT + 1);
        end
        checkOutput("req_ready", 128'(req_ready), 128'(exp_ready));
        checkOutput("busy", 128'(busy), 128'(m_busy));
        checkOutput("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
        if (exp_rv) begin
            checkOutput("rsp_data", 128'(rsp_data), 128'(m_data));
            checkOutput("rsp_id", 128'(rsp_id), 128'(m_id));
        end
        checkOutput("fma_regs", 128'({fma_in1, fma_in2, fma_in3, fma_op_N, fma_op_sub}),
                    128'({m_f1, m_f2, m_f3, m_fn, m_fs}));
    endtask

    task automatic modelEdge();
        bit g;
        int e;
        e = k + 1;
        if (!m_busy && |req_valid) begin
            g      = pick(req_valid, m_last);
            m_acc  = e;
            m_id   = g;
            m_last = g;
            m_f1   = g ? req_in1[63:32] : req_in1[31:0];
            m_f2   = g ? req_in2[63:32] : req_in2[31:0];
            m_f3   = g ? req_in3[63:32] : req_in3[31:0];
            m_fn   = req_op_N[g];
            m_fs   = req_op_sub[g];
            m_data = fma_stub(m_f1, m_f2, m_f3, m_fn, m_fs);
            m_busy = 1'b1;
        end else if (m_busy && e >= m_acc + LAT + 1 && rsp_ready) begin
            m_busy = 1'b0;
        end
        k = e;
    endtask

    // One cycle: drive just after the edge, check mid-cycle, update model at edge.
    task automatic runCycles(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(mode);
            @(negedge clk);
            checkCycle();
            @(posedge clk);
            modelEdge();
            #1;
        end
    endtask

    // Assert reset just after an edge, check everything is cleared at once,
    // release just after the following edge.
    task automatic pulseReset(input string tag);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        #1;
        checkOutput({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
        checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
        checkOutput({tag, "_req_ready"}, 128'(req_ready), 128'(0));
        checkOutput({tag, "_rsp_id"}, 128'(rsp_id), 128'(0));
        checkOutput({tag, "_rsp_data"}, 128'(rsp_data), 128'(0));
        checkOutput({tag, "_fma_regs"},
                    128'({fma_in1, fma_in2, fma_in3, fma_op_N, fma_op_sub}), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        bit found;
        modelReset();
        @(posedge clk);
        #1;
        pulseReset("reset");

        runCycles(5, 2);
        runCycles(0, 8);
        runCycles(1, 16);
        runCycles(2, 20);
        runCycles(2, 3);
        runCycles(4, 8);
        runCycles(2, 10);
        runCycles(3, 300);

        // Get into the middle of an operation, then reset it away.
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            runCycles(2, 1);
            if (m_busy && k < m_acc + LAT) found = 1'b1;
        end
        checkOutput("reach_exec", 128'(found), 128'(1));
        pulseReset("exec_reset");
        runCycles(2, 20);
        runCycles(3, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
